// File: rtl/inm_gen_pipe.sv
// inm_gen_pipe: RISC-V immediate/format decoder with valid/ready buffering.
// Emits sign-extended immediate, format code, next/branch target, illegal count.
module inm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] inm,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] target,
  output logic            illegal,
  output logic [15:0]     illegal_cnt
);

  logic [2:0]         w_fmt;
  logic               w_ill;
  logic               w_rel;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_inm;
  logic [XLEN-1:0]    w_tgt;
  logic               w_push;
  logic               w_pop;

  logic [1:0]         r_occ;
  logic [XLEN-1:0]    r_inm1;
  logic [XLEN-1:0]    r_tgt1;
  logic [2:0]         r_fmt1;
  logic               r_ill1;

  always_comb begin
    w_fmt = 3'd7;
    w_ill = 1'b1;
    w_rel = 1'b0;
    unique case (inst[6:0])
      7'b0110011: begin
        w_fmt = 3'd0;
        w_ill = 1'b0;
      end
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: begin
        w_fmt = 3'd1;
        w_ill = 1'b0;
      end
      7'b0100011: begin
        w_fmt = 3'd2;
        w_ill = 1'b0;
      end
      7'b1100011: begin
        w_fmt = 3'd3;
        w_ill = 1'b0;
        w_rel = 1'b1;
      end
      7'b0110111: begin
        w_fmt = 3'd4;
        w_ill = 1'b0;
      end
      7'b0010111: begin
        w_fmt = 3'd4;
        w_ill = 1'b0;
        w_rel = 1'b1;
      end
      7'b1101111: begin
        w_fmt = 3'd5;
        w_ill = 1'b0;
        w_rel = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    unique case (w_fmt)
      3'd1: w_imm32 = {{20{inst[31]}}, inst[31:20]};
      3'd2: w_imm32 = {{20{inst[31]}}, inst[31:25],
                       inst[11:7]};
      3'd3: w_imm32 = {{19{inst[31]}}, inst[31], inst[7],
                       inst[30:25], inst[11:8], 1'b0};
      3'd4: w_imm32 = {inst[31:12], 12'b0};
      3'd5: w_imm32 = {{11{inst[31]}}, inst[31],
                       inst[19:12], inst[20],
                       inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // signed cast sign-extends the 32-bit immediate for XLEN=64
  assign w_inm = XLEN'(w_imm32);
  assign w_tgt = pc + (w_rel ? w_inm : XLEN'(4));

  assign out_valid = (r_occ != 2'd0);

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (r_occ != 2'd2) && !flush;
    end else begin : g_reg
      assign in_ready = (!out_valid || out_ready) && !flush;
    end
  endgenerate

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_occ       <= 2'd0;
      inm         <= '0;
      fmt         <= 3'd0;
      target      <= '0;
      illegal     <= 1'b0;
      r_inm1      <= '0;
      r_tgt1      <= '0;
      r_fmt1      <= 3'd0;
      r_ill1      <= 1'b0;
      illegal_cnt <= 16'd0;
    end else begin
      if (w_push && w_ill && (illegal_cnt != 16'hFFFF))
        illegal_cnt <= illegal_cnt + 16'd1;
      if (flush) begin
        r_occ <= 2'd0;
      end else begin
        case (r_occ)
          2'd0: begin
            if (w_push) begin
              inm     <= w_inm;
              fmt     <= w_fmt;
              target  <= w_tgt;
              illegal <= w_ill;
              r_occ   <= 2'd1;
            end
          end
          2'd1: begin
            if (w_push && w_pop) begin
              inm     <= w_inm;
              fmt     <= w_fmt;
              target  <= w_tgt;
              illegal <= w_ill;
            end else if (w_pop) begin
              r_occ <= 2'd0;
            end else if (w_push) begin
              r_inm1 <= w_inm;
              r_fmt1 <= w_fmt;
              r_tgt1 <= w_tgt;
              r_ill1 <= w_ill;
              r_occ  <= 2'd2;
            end
          end
          2'd2: begin
            // push is blocked at full, so a pop only promotes the skid entry
            if (w_pop) begin
              inm     <= r_inm1;
              fmt     <= r_fmt1;
              target  <= r_tgt1;
              illegal <= r_ill1;
              r_occ   <= 2'd1;
            end
          end
          default: r_occ <= 2'd0;
        endcase
      end
    end
  end

endmodule
